// File: rtl/alu_mul_sequencer_if.sv
// Start/ready request and valid/ready result handshake bundle for alu_mul_sequencer.
interface alu_mul_sequencer_if #(
  parameter int unsigned XLEN = 32
);
  logic            i_start;
  logic            o_ready;
  logic [XLEN-1:0] i_operand1;
  logic [XLEN-1:0] i_operand2;
  logic            o_valid;
  logic            i_result_ready;
  logic [XLEN-1:0] o_result;

  modport master (
    output i_start, i_operand1, i_operand2, i_result_ready,
    input  o_ready, o_valid, o_result
  );

  modport slave (
    input  i_start, i_operand1, i_operand2, i_result_ready,
    output o_ready, o_valid, o_result
  );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Iterative shift-and-add multiplier (low XLEN bits) that borrows the shared ALU for one add per cycle.
// Optional MUL_SEQ_EARLY_EXIT_EN: finish as soon as no multiplier bits remain.
package alu_mul_sequencer_pkg;
  typedef logic [31:0] t_data;

  typedef enum logic [3:0] {
    ALU_OP_ADD  = 4'd0,
    ALU_OP_SUB  = 4'd1,
    ALU_OP_AND  = 4'd2,
    ALU_OP_OR   = 4'd3,
    ALU_OP_XOR  = 4'd4,
    ALU_OP_SLL  = 4'd5,
    ALU_OP_SRL  = 4'd6,
    ALU_OP_SRA  = 4'd7,
    ALU_OP_SLT  = 4'd8,
    ALU_OP_SLTU = 4'd9
  } t_alu_operation;
endpackage

module alu_mul_sequencer
  import alu_mul_sequencer_pkg::*;
#(
  parameter  int unsigned XLEN  = 32,
  localparam int unsigned CNT_W = $clog2(XLEN)
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  alu_mul_sequencer_if.slave     bus,
  output logic                   o_alu_request,
  output t_alu_operation         o_alu_operation,
  output logic [XLEN-1:0]        o_alu_operand1,
  output logic [XLEN-1:0]        o_alu_operand2,
  input  logic [XLEN-1:0]        i_alu_result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } t_state;

  t_state            r_state;
  logic              r_ready;
  logic              r_valid;
  logic              r_alu_request;
  logic [XLEN-1:0]   r_result;
  logic [XLEN-1:0]   r_acc;
  logic [XLEN-1:0]   r_mcand;
  logic [XLEN-1:0]   r_mplier;
  logic [CNT_W-1:0]  r_count;
  logic              w_last;

  // Last RUN cycle: fixed iteration count, or (early exit) no multiplier bits left after this one.
  always_comb begin
    w_last = (r_count == CNT_W'(XLEN - 1));
`ifdef MUL_SEQ_EARLY_EXIT_EN
    w_last = w_last || (r_mplier[XLEN-1:1] == '0);
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_ready       <= 1'b1;
      r_valid       <= 1'b0;
      r_result      <= '0;
      r_alu_request <= 1'b0;
      r_acc         <= '0;
      r_mcand       <= '0;
      r_mplier      <= '0;
      r_count       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_start) begin
            r_mcand  <= bus.i_operand1;
            r_mplier <= bus.i_operand2;
            r_acc    <= '0;
            r_count  <= '0;
            r_ready  <= 1'b0;
`ifdef MUL_SEQ_EARLY_EXIT_EN
            if (bus.i_operand2 == '0) begin
              r_state  <= S_DONE;
              r_valid  <= 1'b1;
              r_result <= '0;
            end else begin
              r_state       <= S_RUN;
              r_alu_request <= 1'b1;
            end
`else
            r_state       <= S_RUN;
            r_alu_request <= 1'b1;
`endif
          end
        end

        S_RUN: begin
          r_acc    <= i_alu_result;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count + 1'b1;
          if (w_last) begin
            r_state       <= S_DONE;
            r_alu_request <= 1'b0;
            r_valid       <= 1'b1;
            r_result      <= i_alu_result;
          end
        end

        S_DONE: begin
          if (bus.i_result_ready) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
          end
        end

        default: begin
          r_state       <= S_IDLE;
          r_ready       <= 1'b1;
          r_valid       <= 1'b0;
          r_alu_request <= 1'b0;
        end
      endcase
    end
  end

  // ALU operands are only meaningful while the ALU is owned; otherwise park at zero.
  always_comb begin
    o_alu_operation = ALU_OP_ADD;
    o_alu_operand1  = '0;
    o_alu_operand2  = '0;
    if (r_state == S_RUN) begin
      o_alu_operand1 = r_acc;
      o_alu_operand2 = r_mplier[0] ? r_mcand : '0;
    end
  end

  assign o_alu_request = r_alu_request;
  assign bus.o_ready   = r_ready;
  assign bus.o_valid   = r_valid;
  assign bus.o_result  = r_result;

  a_ready_valid_exclusive : assert property (
    @(posedge i_clk) disable iff (i_reset) !(r_ready && r_valid));

  a_request_matches_run : assert property (
    @(posedge i_clk) disable iff (i_reset) (r_alu_request == (r_state == S_RUN)));

  a_result_held_under_backpressure : assert property (
    @(posedge i_clk) disable iff (i_reset)
      (r_valid && !bus.i_result_ready) |=> (r_valid && $stable(r_result)));

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Self-checking bench for alu_mul_sequencer: random operands against a plain-arithmetic product/latency model.
module tb_alu_mul_sequencer;
  import alu_mul_sequencer_pkg::*;

  localparam int unsigned XLEN = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_mul_sequencer_if #(.XLEN(XLEN)) mbus ();

  logic            alu_req;
  t_alu_operation  alu_op;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] alu_y;

  // Execute-stage ALU stand-in.
  always_comb begin
    case (alu_op)
      ALU_OP_ADD: alu_y = alu_a + alu_b;
      ALU_OP_SUB: alu_y = alu_a - alu_b;
      ALU_OP_AND: alu_y = alu_a & alu_b;
      ALU_OP_OR:  alu_y = alu_a | alu_b;
      ALU_OP_XOR: alu_y = alu_a ^ alu_b;
      default:    alu_y = '0;
    endcase
  end

  alu_mul_sequencer #(.XLEN(XLEN)) dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .bus             (mbus),
    .o_alu_request   (alu_req),
    .o_alu_operation (alu_op),
    .o_alu_operand1  (alu_a),
    .o_alu_operand2  (alu_b),
    .i_alu_result    (alu_y)
  );

  int total = 0;
  int bad   = 0;

  function automatic logic [31:0] model_mul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    return p[31:0];
  endfunction

  // Number of cycles the ALU is borrowed for a given multiplier.
  function automatic int model_run(input logic [31:0] b);
`ifdef MUL_SEQ_EARLY_EXIT_EN
    for (int i = 31; i >= 0; i--)
      if (b[i]) return i + 1;
    return 0;
`else
    return (b == 32'd0) ? 32 : 32;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one multiply; cycle 0 is the accepting cycle. Reports observed latency and ALU usage.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit handshake,
                        output logic [31:0] res, output int vcyc, output int nreq,
                        output int first_req, output int last_req, output bit op_err);
    int w;
    w = 0;
    while (!mbus.o_ready && w < 100) begin
      tick();
      w++;
    end
    mbus.i_start    = 1'b1;
    mbus.i_operand1 = a;
    mbus.i_operand2 = b;
    tick();
    mbus.i_start    = 1'b0;
    mbus.i_operand1 = $urandom;
    mbus.i_operand2 = $urandom;
    vcyc = -1; nreq = 0; first_req = -1; last_req = -1; op_err = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      if (alu_req) begin
        nreq++;
        if (first_req < 0) first_req = c;
        last_req = c;
        if (alu_op != ALU_OP_ADD) op_err = 1'b1;
      end
      if (mbus.o_valid) begin
        vcyc = c;
        break;
      end
      tick();
    end
    res = mbus.o_result;
    if (handshake) begin
      mbus.i_result_ready = 1'b1;
      tick();
      mbus.i_result_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mbus.i_start = 1'b0; mbus.i_result_ready = 1'b0;
    mbus.i_operand1 = '0; mbus.i_operand2 = '0;
    repeat (3) tick();
    rst = 1'b0;
    total++; if (mbus.o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", mbus.o_ready); end
    total++; if (mbus.o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", mbus.o_valid); end
    total++; if (mbus.o_result !== 32'd0) begin bad++; $display("FAIL reset_result got=%h want=0", mbus.o_result); end
    total++; if (alu_req !== 1'b0) begin bad++; $display("FAIL reset_alu_req got=%b want=0", alu_req); end
    total++; if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_op !== ALU_OP_ADD) begin
      bad++; $display("FAIL reset_alu_bus got=%h/%h/%0d want=0/0/ADD", alu_a, alu_b, alu_op);
    end
  endtask

  task automatic test_basic();
    logic [31:0] r; int v, n, f, l; bit e;
    run_op(32'd7, 32'd6, 1'b1, r, v, n, f, l, e);
    total++; if (r !== 32'd42) begin bad++; $display("FAIL basic_result got=%0d want=42", r); end
    total++; if (v !== model_run(32'd6) + 1) begin bad++; $display("FAIL basic_latency got=%0d want=%0d", v, model_run(32'd6) + 1); end
    total++; if (n !== model_run(32'd6) || f !== 1 || l !== model_run(32'd6)) begin
      bad++; $display("FAIL basic_alu_window got=n%0d first%0d last%0d want n%0d 1..%0d", n, f, l, model_run(32'd6), model_run(32'd6));
    end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL basic_alu_op got=non-ADD want=ADD"); end
  endtask

  task automatic test_wrap();
    logic [31:0] r; int v, n, f, l; bit e;
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, r, v, n, f, l, e);
    total++; if (r !== 32'h0000_0001) begin bad++; $display("FAIL wrap_allones got=%h want=00000001", r); end
    total++; if (v !== model_run(32'hFFFF_FFFF) + 1) begin bad++; $display("FAIL wrap_allones_latency got=%0d want=%0d", v, model_run(32'hFFFF_FFFF) + 1); end
    run_op(32'hFFFF_FFFD, 32'd5, 1'b1, r, v, n, f, l, e);
    total++; if (r !== 32'hFFFF_FFF1) begin bad++; $display("FAIL wrap_neg3x5 got=%h want=fffffff1", r); end
  endtask

  task automatic test_random();
    logic [31:0] a, b, r; int v, n, f, l; bit e;
    for (int i = 0; i < 12; i++) begin
      a = $urandom;
      case (i % 4)
        0: b = $urandom;
        1: b = $urandom >> $urandom_range(0, 31);
        2: b = 32'd1 << $urandom_range(0, 31);
        default: b = (i == 3) ? 32'd0 : ($urandom & 32'h0000_00FF);
      endcase
      run_op(a, b, 1'b1, r, v, n, f, l, e);
      total++; if (r !== model_mul(a, b)) begin bad++; $display("FAIL rand_result[%0d] a=%h b=%h got=%h want=%h", i, a, b, r, model_mul(a, b)); end
      total++; if (v !== model_run(b) + 1 || n !== model_run(b)) begin
        bad++; $display("FAIL rand_timing[%0d] b=%h got=v%0d n%0d want=v%0d n%0d", i, b, v, n, model_run(b) + 1, model_run(b));
      end
      total++; if (e !== 1'b0) begin bad++; $display("FAIL rand_alu_op[%0d] got=non-ADD want=ADD", i); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] r; int v, n, f, l; bit e; int errs;
    run_op(32'd1234, 32'd5678, 1'b0, r, v, n, f, l, e);
    total++; if (r !== model_mul(32'd1234, 32'd5678)) begin bad++; $display("FAIL bp_result got=%h want=%h", r, model_mul(32'd1234, 32'd5678)); end
    errs = 0;
    for (int c = 0; c < 10; c++) begin
      mbus.i_start    = (c % 2 == 0);
      mbus.i_operand1 = $urandom;
      mbus.i_operand2 = $urandom;
      tick();
      if (mbus.o_valid !== 1'b1 || mbus.o_ready !== 1'b0 || alu_req !== 1'b0 ||
          mbus.o_result !== model_mul(32'd1234, 32'd5678)) errs++;
    end
    mbus.i_start = 1'b0;
    total++; if (errs != 0) begin bad++; $display("FAIL bp_hold got=%0d bad cycles want=0", errs); end
    mbus.i_result_ready = 1'b1;
    tick();
    mbus.i_result_ready = 1'b0;
    total++; if (mbus.o_ready !== 1'b1 || mbus.o_valid !== 1'b0) begin
      bad++; $display("FAIL bp_release got=ready%b valid%b want=ready1 valid0", mbus.o_ready, mbus.o_valid);
    end
    total++; if (mbus.o_result !== model_mul(32'd1234, 32'd5678)) begin
      bad++; $display("FAIL bp_idle_result got=%h want=%h", mbus.o_result, model_mul(32'd1234, 32'd5678));
    end
    tick();
    total++; if (mbus.o_ready !== 1'b1 || alu_req !== 1'b0) begin
      bad++; $display("FAIL bp_no_queued_start got=ready%b req%b want=ready1 req0", mbus.o_ready, alu_req);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] r; int v, n, f, l; bit e; int seen;
    mbus.i_start = 1'b1; mbus.i_operand1 = 32'h0001_2345; mbus.i_operand2 = 32'h8000_0777;
    tick();
    mbus.i_start = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    total++; if (alu_req !== 1'b1) begin bad++; $display("FAIL midrst_in_run got=%b want=1", alu_req); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (mbus.o_ready !== 1'b1 || mbus.o_valid !== 1'b0 || alu_req !== 1'b0 || mbus.o_result !== 32'd0) begin
      bad++; $display("FAIL midrst_state got=ready%b valid%b req%b res%h want=1 0 0 0", mbus.o_ready, mbus.o_valid, alu_req, mbus.o_result);
    end
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (mbus.o_valid !== 1'b0 || alu_req !== 1'b0) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL midrst_no_result got=%0d active cycles want=0", seen); end
    run_op(32'd3, 32'd3, 1'b1, r, v, n, f, l, e);
    total++; if (r !== 32'd9) begin bad++; $display("FAIL midrst_fresh got=%0d want=9", r); end
  endtask

`ifdef MUL_SEQ_EARLY_EXIT_EN
  task automatic test_early_exit();
    logic [31:0] r; int v, n, f, l; bit e;
    run_op(32'd5, 32'd3, 1'b1, r, v, n, f, l, e);
    total++; if (r !== 32'd15 || v !== 3 || n !== 2) begin
      bad++; $display("FAIL early_5x3 got=res%0d v%0d n%0d want=res15 v3 n2", r, v, n);
    end
    run_op(32'd9, 32'd0, 1'b1, r, v, n, f, l, e);
    total++; if (r !== 32'd0 || v !== 1 || n !== 0) begin
      bad++; $display("FAIL early_9x0 got=res%0d v%0d n%0d want=res0 v1 n0", r, v, n);
    end
  endtask
`endif

  task automatic test_back_to_back();
    logic [31:0] r; int v, n, f, l; bit e;
    run_op(32'd2, 32'd3, 1'b1, r, v, n, f, l, e);
    total++; if (r !== 32'd6) begin bad++; $display("FAIL b2b_first got=%0d want=6", r); end
    total++; if (mbus.o_valid !== 1'b0 || mbus.o_ready !== 1'b1) begin
      bad++; $display("FAIL b2b_gap got=valid%b ready%b want=valid0 ready1", mbus.o_valid, mbus.o_ready);
    end
    run_op(32'd4, 32'd5, 1'b1, r, v, n, f, l, e);
    total++; if (r !== 32'd20 || v !== model_run(32'd5) + 1) begin
      bad++; $display("FAIL b2b_second got=res%0d v%0d want=res20 v%0d", r, v, model_run(32'd5) + 1);
    end
    total++; if (mbus.o_valid !== 1'b0) begin bad++; $display("FAIL b2b_no_dup_valid got=%b want=0", mbus.o_valid); end
  endtask

  initial begin
    #200_000;
    bad++;
    $display("FAIL watchdog got=timeout want=completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_random();
    test_backpressure();
    test_reset_mid_run();
`ifdef MUL_SEQ_EARLY_EXIT_EN
    test_early_exit();
`endif
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
